// File: rtl/addsub_if.sv
// Operand/result bundle between an operand source and the registered adder/subtractor.
// Latency: none (wires only); the registering happens inside addsub.
// Backpressure: none; the source drives operands every cycle and the results update every cycle.
//
// Signals:
//   iOPCODE   0 = add, 1 = subtract (A - B)
//   iDATAIN1  operand A
//   iDATAIN2  operand B
//   oDATAOUT  registered result, modulo 2^WIDTH
//   oCARRY    add: carry out of MSB; sub: borrow (A < B unsigned)
//   oOVF      signed overflow of the operation
//   oZERO     registered result == 0
// Modports: master = operand source / result consumer, slave = addsub.
interface addsub_if #(
    parameter int WIDTH = 8
);
    logic             iOPCODE;
    logic [WIDTH-1:0] iDATAIN1;
    logic [WIDTH-1:0] iDATAIN2;
    logic [WIDTH-1:0] oDATAOUT;
    logic             oCARRY;
    logic             oOVF;
    logic             oZERO;

    modport master (
        output iOPCODE,
        output iDATAIN1,
        output iDATAIN2,
        input  oDATAOUT,
        input  oCARRY,
        input  oOVF,
        input  oZERO
    );

    modport slave (
        input  iOPCODE,
        input  iDATAIN1,
        input  iDATAIN2,
        output oDATAOUT,
        output oCARRY,
        output oOVF,
        output oZERO
    );
endinterface

// File: rtl/addsub.sv
// Registered WIDTH-bit adder/subtractor with carry/borrow, signed-overflow and zero flags.
// Latency: 1 cycle; operands sampled at a rising iCLK edge appear on the outputs right after it.
// Backpressure: none; every edge captures and the outputs update every cycle.
//
// Ports:
//   iCLK  clock, rising-edge active
//   iRST  asynchronous active-high reset; clears result and all flags immediately
//   bus   addsub_if slave modport: iOPCODE/iDATAIN1/iDATAIN2 in,
//         oDATAOUT/oCARRY/oOVF/oZERO out
module addsub #(
    parameter int WIDTH = 8
) (
    input  logic      iCLK,
    input  logic      iRST,
    addsub_if.slave   bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] opB;      // B for add, ~B for subtract
    logic [WIDTH:0]   sum;      // {c, r}
    logic [WIDTH-1:0] result;
    logic             carryOut;
    logic             ovf;

    // Subtraction reuses the adder as A + ~B + 1; the opcode bit doubles as the +1.
    always_comb begin
        opB      = bus.iOPCODE ? ~bus.iDATAIN2 : bus.iDATAIN2;
        sum      = {1'b0, bus.iDATAIN1} + {1'b0, opB} + {{WIDTH{1'b0}}, bus.iOPCODE};
        result   = sum[WIDTH-1:0];
        // For subtract the raw carry is "no borrow", so invert it to report borrow.
        carryOut = sum[WIDTH] ^ bus.iOPCODE;
        // Comparing A against the effective addend covers both cases: for subtract
        // opB[MSB] is ~B[MSB], so "signs equal" becomes "signs of A and B differ".
        ovf      = (bus.iDATAIN1[MSB] == opB[MSB]) && (result[MSB] != bus.iDATAIN1[MSB]);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bus.oDATAOUT <= '0;
            bus.oCARRY   <= 1'b0;
            bus.oOVF     <= 1'b0;
            bus.oZERO    <= 1'b0;
        end else begin
            bus.oDATAOUT <= result;
            bus.oCARRY   <= carryOut;
            bus.oOVF     <= ovf;
            bus.oZERO    <= (result == '0);
        end
    end
endmodule

// File: tb/tb_addsub.sv
// Self-checking bench for addsub: directed cases plus a scoreboarded random stream.
// Latency: expects results one rising edge after operands are driven.
// Backpressure: none; operands are driven once per cycle.
module tb_addsub;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             c;
        logic             v;
        logic             z;
    } expT;

    logic iCLK  = 1'b0;
    logic iRST  = 1'b1;
    logic clkEn = 1'b0;

    int   vecCount  = 0;
    int   missCount = 0;
    expT  sbQ[$];

    addsub_if #(.WIDTH(WIDTH)) bus ();

    addsub #(.WIDTH(WIDTH)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus.slave)
    );

    always begin
        #5;
        if (clkEn) iCLK = ~iCLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference in plain integers: unsigned for carry/borrow, signed range for overflow.
    function automatic expT model(input bit op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        expT e;
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!op) begin
            ur  = ua + ub;
            sr  = sa + sb;
            e.c = (ur > 255);
        end else begin
            ur  = ua - ub;
            sr  = sa - sb;
            e.c = (ua < ub);
        end
        e.data = ur[WIDTH-1:0];
        e.v    = (sr > 127) || (sr < -128);
        e.z    = (e.data == 0);
        return e;
    endfunction

    task automatic checkOutputs(input string tag, input expT e);
        checkVal({tag, ".data"},  int'(bus.oDATAOUT), int'(e.data));
        checkVal({tag, ".carry"}, int'(bus.oCARRY),   int'(e.c));
        checkVal({tag, ".ovf"},   int'(bus.oOVF),     int'(e.v));
        checkVal({tag, ".zero"},  int'(bus.oZERO),    int'(e.z));
    endtask

    task automatic popCompare(input string tag);
        expT e;
        if (sbQ.size() == 0) begin
            checkVal({tag, ".sbEmpty"}, 0, 1);
        end else begin
            e = sbQ.pop_front();
            checkOutputs(tag, e);
        end
    endtask

    task automatic applyExp(input string tag, input bit op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input expT e);
        @(negedge iCLK);
        bus.iOPCODE  = op;
        bus.iDATAIN1 = a;
        bus.iDATAIN2 = b;
        sbQ.push_back(e);
        @(posedge iCLK);
        #1;
        popCompare(tag);
    endtask

    task automatic applyRand(input string tag);
        bit               op;
        logic [WIDTH-1:0] a, b;
        op = 1'($urandom_range(0, 1));
        a  = WIDTH'($urandom_range(0, 255));
        b  = WIDTH'($urandom_range(0, 255));
        applyExp(tag, op, a, b, model(op, a, b));
    endtask

    initial begin
        expT zeroE;
        expT holdE;
        zeroE = '{data: 8'h00, c: 1'b0, v: 1'b0, z: 1'b0};

        // Reset held with no clock at all: outputs must already be cleared.
        bus.iOPCODE  = 1'b0;
        bus.iDATAIN1 = 8'h01;
        bus.iDATAIN2 = 8'h03;
        #7;
        checkOutputs("rstNoClk", zeroE);

        // Clock running while still in reset: nothing is captured.
        clkEn = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        checkOutputs("rstClk", zeroE);

        @(negedge iCLK);
        iRST = 1'b0;

        // Directed arithmetic cases.
        applyExp("add1",    1'b0, 8'h01, 8'h03, '{data: 8'h04, c: 1'b0, v: 1'b0, z: 1'b0});
        applyExp("addWrap", 1'b0, 8'hFF, 8'h01, '{data: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1});
        applyExp("addOvf",  1'b0, 8'h7F, 8'h01, '{data: 8'h80, c: 1'b0, v: 1'b1, z: 1'b0});
        applyExp("sub1",    1'b1, 8'h05, 8'h03, '{data: 8'h02, c: 1'b0, v: 1'b0, z: 1'b0});
        applyExp("subBorr", 1'b1, 8'h03, 8'h05, '{data: 8'hFE, c: 1'b1, v: 1'b0, z: 1'b0});
        applyExp("subOvf",  1'b1, 8'h80, 8'h01, '{data: 8'h7F, c: 1'b0, v: 1'b1, z: 1'b0});
        applyExp("subZero", 1'b1, 8'h80, 8'h80, '{data: 8'h00, c: 1'b0, v: 1'b0, z: 1'b1});

        // Hold: operand changes while the clock is low do not reach the outputs.
        holdE = '{data: 8'h00, c: 1'b0, v: 1'b0, z: 1'b1};
        @(negedge iCLK);
        bus.iOPCODE  = 1'b0;
        bus.iDATAIN1 = 8'h10;
        bus.iDATAIN2 = 8'h20;
        #1;
        checkOutputs("holdLow", holdE);
        // Opcode toggled before the edge: the value present at the edge wins.
        #2;
        bus.iOPCODE = 1'b1;
        sbQ.push_back('{data: 8'hF0, c: 1'b1, v: 1'b0, z: 1'b0});
        @(posedge iCLK);
        #1;
        popCompare("opAtEdge");
        // Changes while the clock is high do not reach the outputs either.
        bus.iOPCODE  = 1'b0;
        bus.iDATAIN1 = 8'h01;
        bus.iDATAIN2 = 8'h01;
        #2;
        checkOutputs("holdHigh", '{data: 8'hF0, c: 1'b1, v: 1'b0, z: 1'b0});

        // Random stream, mid-run asynchronous reset, then more random stream.
        for (int i = 0; i < 40; i++) applyRand("rndA");
        @(posedge iCLK);
        #2;
        iRST = 1'b1;
        #1;
        checkOutputs("midRst", zeroE);
        sbQ.delete();
        @(negedge iCLK);
        iRST = 1'b0;
        for (int i = 0; i < 40; i++) applyRand("rndB");

        checkVal("sbDrained", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
